// File: rtl/gate_sequencer_pkg.sv
// Shared types and register map for the gate sequencer.
package gate_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_EXT   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESCALE = 3'd1;
  localparam logic [2:0] ADDR_WIDTH    = 3'd2;
  localparam logic [2:0] ADDR_PERIOD   = 3'd3;
  localparam logic [2:0] ADDR_BURST    = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_COUNT    = 3'd6;

endpackage

// File: rtl/gate_sequencer_pedge.sv
// Registered rising-edge detector; pulse is one cycle wide, one cycle late.
module gate_sequencer_pedge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic din_q;

  // Edge history and registered pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      din_q <= din;
      pulse <= din & ~din_q;
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// Programmable gate generator: prescaled width/period, single/cont/burst/ext runs.
//
// state   | meaning
// IDLE    | no run active, gate low, waiting for a start condition
// HIGH    | gate high, counting w_eff ticks
// LOW     | gate low, counting (p_eff - w_eff) ticks, then repeat or stop
module gate_sequencer
  import gate_sequencer_pkg::*;
#(
  parameter int PRE_W   = 8,
  parameter int CNT_W   = 24,
  parameter int BURST_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ext_trig,
  output logic        gate,
  output logic        gate_start,
  output logic        busy
);

  localparam logic [PRE_W-1:0]   PRE_ONE   = PRE_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  state_t               state, state_next;
  mode_t                mode, wr_mode;
  logic [PRE_W-1:0]     prescale, pre_sh, pre_cnt;
  logic [CNT_W-1:0]     width, period, low_sh, tick_cnt, w_eff, low_eff;
  logic [BURST_W-1:0]   burst, remaining;
  logic [31:0]          gate_count;
  logic                 run_once, ext_pulse;
  logic                 wr_ctrl, single_req, abort_req, cont_req, burst_req, ext_req;
  logic                 start_idle, load_run, tick, phase_end;
  logic                 unused_bits;

  gate_sequencer_pedge u_pedge (
    .clk   (clk),
    .reset (reset),
    .din   (ext_trig),
    .pulse (ext_pulse)
  );

  assign wr_ctrl     = write && (address == ADDR_CTRL);
  assign wr_mode     = mode_t'(writedata[1:0]);
  assign single_req  = wr_ctrl && writedata[2];
  assign abort_req   = wr_ctrl && writedata[3];
  assign cont_req    = wr_ctrl && (wr_mode == MODE_CONT);
  assign burst_req   = wr_ctrl && (wr_mode == MODE_BURST) && (burst != '0);
  assign ext_req     = ext_pulse && (mode == MODE_EXT);
  assign unused_bits = ^writedata;

  // Low phase is kept as a tick count so w_eff+1 is never formed and cannot wrap.
  assign w_eff     = (width == '0) ? CNT_ONE : width;
  assign low_eff   = (period > w_eff) ? (period - w_eff) : CNT_ONE;
  assign tick      = (pre_cnt == '0);
  assign phase_end = tick && (tick_cnt == '0);
  assign busy      = (state != ST_IDLE);

  // Next-state logic; abort overrides every start and phase transition.
  always_comb begin
    state_next = state;
    load_run   = 1'b0;
    start_idle = 1'b0;
    if (abort_req) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (single_req || cont_req || burst_req || ext_req) begin
            state_next = ST_HIGH;
            load_run   = 1'b1;
            start_idle = 1'b1;
          end
        end
        ST_HIGH: begin
          if (phase_end) state_next = ST_LOW;
        end
        ST_LOW: begin
          if (phase_end) begin
            if (!run_once && ((mode == MODE_CONT) ||
                              ((mode == MODE_BURST) && (remaining > BURST_ONE)))) begin
              state_next = ST_HIGH;
              load_run   = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register and registered gate outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      gate       <= 1'b0;
      gate_start <= 1'b0;
    end else begin
      state      <= state_next;
      gate       <= (state_next == ST_HIGH);
      gate_start <= load_run;
    end
  end

  // Configuration registers; mode follows every control write, strobes are not stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode     <= MODE_OFF;
      prescale <= '0;
      width    <= '0;
      period   <= '0;
      burst    <= '0;
    end else if (write) begin
      case (address)
        ADDR_CTRL:     mode     <= wr_mode;
        ADDR_PRESCALE: prescale <= writedata[PRE_W-1:0];
        ADDR_WIDTH:    width    <= writedata[CNT_W-1:0];
        ADDR_PERIOD:   period   <= writedata[CNT_W-1:0];
        ADDR_BURST:    burst    <= writedata[BURST_W-1:0];
        default: ;
      endcase
    end
  end

  // Run bookkeeping: burst count, one-shot flag, shadows, prescaler and tick counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining  <= '0;
      run_once   <= 1'b0;
      pre_sh     <= '0;
      low_sh     <= '0;
      pre_cnt    <= '0;
      tick_cnt   <= '0;
      gate_count <= '0;
    end else begin
      if (abort_req)
        remaining <= '0;
      else if (start_idle && burst_req && !single_req)
        remaining <= burst;
      else if ((state == ST_LOW) && phase_end && !run_once &&
               (mode == MODE_BURST) && (remaining != '0))
        remaining <= remaining - BURST_ONE;

      if (start_idle)
        run_once <= single_req || !(cont_req || burst_req);

      if (load_run) begin
        pre_sh     <= prescale;
        low_sh     <= low_eff;
        pre_cnt    <= prescale;
        tick_cnt   <= w_eff - CNT_ONE;
        gate_count <= gate_count + 32'd1;
      end else if (state != ST_IDLE) begin
        if (tick) begin
          pre_cnt  <= pre_sh;
          tick_cnt <= ((state == ST_HIGH) && phase_end) ? (low_sh - CNT_ONE)
                                                         : (tick_cnt - CNT_ONE);
        end else begin
          pre_cnt <= pre_cnt - PRE_ONE;
        end
      end
    end
  end

  // Combinational read mux; write-only and unmapped addresses read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: readdata = {busy, state, mode, 11'd0, 16'(remaining)};
      ADDR_COUNT:  readdata = gate_count;
      default:     readdata = '0;
    endcase
  end

endmodule
